// File: rtl/neo_pkg.sv
// rtl/neo_pkg.sv - shared encodings and state type for the NeoPixel frame sequencer
package neo_pkg;
    localparam int MAX_PIXELS = 8;
    localparam int PIX_W      = $clog2(MAX_PIXELS);

    localparam logic [1:0] COLOR_RED   = 2'b00;
    localparam logic [1:0] COLOR_BLUE  = 2'b01;
    localparam logic [1:0] COLOR_GREEN = 2'b10;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, HOLD} state_e;
endpackage

// File: rtl/neo_frame_sequencer_if.sv
// rtl/neo_frame_sequencer_if.sv - host write port plus strand controller load/send handshake
interface neo_frame_sequencer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_pixel;
    logic [1:0] wr_color;
    logic [7:0] wr_level;
    logic       commit;
    logic       ready_to_load;
    logic       ready_to_send;
    logic [7:0] color_level;
    logic [1:0] color_index;
    logic [2:0] pixel_index;
    logic       load_color;
    logic       send_it;
    logic       busy;
    logic [7:0] frames_sent;

    modport master (
        output wr_valid, wr_pixel, wr_color, wr_level, commit, ready_to_load, ready_to_send,
        input  wr_ready, color_level, color_index, pixel_index, load_color, send_it, busy, frames_sent
    );

    modport slave (
        input  wr_valid, wr_pixel, wr_color, wr_level, commit, ready_to_load, ready_to_send,
        output wr_ready, color_level, color_index, pixel_index, load_color, send_it, busy, frames_sent
    );
endinterface

// File: rtl/neo_shadow_frame.sv
// rtl/neo_shadow_frame.sv - per-pixel colour bytes with a dirty bit each; host write, scan read
module neo_shadow_frame
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_pixel,
    input  logic [1:0]       wr_color,
    input  logic [7:0]       wr_level,
    input  logic [PIX_W-1:0] rd_pixel,
    input  logic [1:0]       rd_color,
    output logic [7:0]       rd_level,
    output logic             rd_dirty,
    input  logic             clr_dirty
);
    logic [7:0] level_mem [NUM_PIXELS][3];
    logic [2:0] dirty     [NUM_PIXELS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PIXELS; p++) begin
                dirty[p] <= '0;
                for (int c = 0; c < 3; c++) level_mem[p][c] <= '0;
            end
        end else begin
            if (clr_dirty) dirty[rd_pixel][rd_color] <= 1'b0;
            // a host write landing on the scanned byte keeps it dirty
            if (wr_en) begin
                level_mem[wr_pixel][wr_color] <= wr_level;
                dirty[wr_pixel][wr_color]     <= 1'b1;
            end
        end
    end

    assign rd_level = level_mem[rd_pixel][rd_color];
    assign rd_dirty = dirty[rd_pixel][rd_color];
endmodule

// File: rtl/neo_frame_sequencer.sv
// rtl/neo_frame_sequencer.sv - replays changed shadow bytes into the strand controller, then sends
module neo_frame_sequencer
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS     = 5,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    neo_frame_sequencer_if.slave  bus
);
    localparam int RMAX = (REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0;
    localparam int CW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

    state_e           state;
    logic [PIX_W-1:0] scan_pixel;
    logic [1:0]       scan_color;
    logic             pending_commit;
    logic [7:0]       frames_sent;
    logic [CW-1:0]    refresh_cnt;
    logic [7:0]       rd_level;
    logic             rd_dirty;
    logic             in_load, wr_keep, load_fire, step, last_entry, refresh_hit;

    assign in_load     = (state == LOAD);
    assign wr_keep     = bus.wr_valid && bus.wr_ready && (bus.wr_color != 2'b11)
                         && (32'(bus.wr_pixel) < NUM_PIXELS);
    assign load_fire   = in_load && rd_dirty && bus.ready_to_load;
    assign step        = in_load && (!rd_dirty || bus.ready_to_load);
    assign last_entry  = (32'(scan_pixel) == NUM_PIXELS - 1) && (scan_color == COLOR_GREEN);
    assign refresh_hit = (REFRESH_CYCLES > 0) && (refresh_cnt == CW'(RMAX));

    neo_shadow_frame #(.NUM_PIXELS(NUM_PIXELS)) u_shadow (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (wr_keep),
        .wr_pixel  (bus.wr_pixel),
        .wr_color  (bus.wr_color),
        .wr_level  (bus.wr_level),
        .rd_pixel  (scan_pixel),
        .rd_color  (scan_color),
        .rd_level  (rd_level),
        .rd_dirty  (rd_dirty),
        .clr_dirty (load_fire)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            scan_pixel     <= '0;
            scan_color     <= COLOR_RED;
            pending_commit <= 1'b0;
            frames_sent    <= '0;
            refresh_cnt    <= '0;
        end else begin
            if (bus.commit && state != IDLE) pending_commit <= 1'b1;
            case (state)
                IDLE: begin
                    if (REFRESH_CYCLES > 0 && refresh_cnt != CW'(RMAX))
                        refresh_cnt <= refresh_cnt + CW'(1);
                    // commit outranks a refresh that matures in the same cycle
                    if (bus.commit || pending_commit) begin
                        state          <= LOAD;
                        scan_pixel     <= '0;
                        scan_color     <= COLOR_RED;
                        pending_commit <= 1'b0;
                    end else if (refresh_hit) begin
                        state <= SEND;
                    end
                end
                LOAD: begin
                    if (step) begin
                        if (last_entry) begin
                            state <= SEND;
                        end else if (scan_color == COLOR_GREEN) begin
                            scan_color <= COLOR_RED;
                            scan_pixel <= scan_pixel + 1'b1;
                        end else begin
                            scan_color <= (scan_color == COLOR_RED) ? COLOR_BLUE : COLOR_GREEN;
                        end
                    end
                end
                SEND: begin
                    if (bus.ready_to_send) begin
                        state       <= HOLD;
                        frames_sent <= frames_sent + 8'd1;
                    end
                end
                HOLD: begin
                    // controller dropping ready_to_send means it has started shifting
                    if (!bus.ready_to_send) begin
                        state       <= IDLE;
                        refresh_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_ready    = (state != LOAD);
    assign bus.load_color  = load_fire;
    assign bus.color_level = (in_load && rd_dirty) ? rd_level : 8'd0;
    assign bus.color_index = (in_load && rd_dirty) ? scan_color : 2'd0;
    assign bus.pixel_index = (in_load && rd_dirty) ? scan_pixel : '0;
    assign bus.send_it     = (state == SEND) && bus.ready_to_send;
    assign bus.busy        = (state != IDLE);
    assign bus.frames_sent = frames_sent;
endmodule

// File: tb/tb_neo_frame_sequencer.sv
// tb/tb_neo_frame_sequencer.sv - randomized bench with a shadow/dirty reference model
module tb_neo_frame_sequencer;
    localparam int NP = 5;
    localparam int NE = 3 * NP;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    neo_frame_sequencer_if bus ();
    neo_frame_sequencer_if bus2 ();

    neo_frame_sequencer #(.NUM_PIXELS(NP), .REFRESH_CYCLES(0)) u_dut (
        .clock(clock), .reset_n(reset_n), .bus(bus));
    neo_frame_sequencer #(.NUM_PIXELS(NP), .REFRESH_CYCLES(20)) u_rfr (
        .clock(clock), .reset_n(reset_n), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0]  m_level [NE];
    bit          m_dirty [NE];
    logic [7:0]  m_frames = 8'd0;
    logic [12:0] got_q [$];
    int          got_cyc [$];
    logic [12:0] exp_q [$];
    int cyc = 0, sends_seen = 0, first_send = -1, commit_cyc = 0;
    int rtl_mode = 0, rts_hold = 0;
    bit acc = 0;

    int loads2 = 0, idle2 = 0, gaps2 = 0, hold2 = 0;
    bit armed2 = 0, acc2 = 0;
    logic [12:0] load2_val = '0;

    always @(posedge clock) cyc++;

    // controller stand-in: load readiness per mode; after each accepted send it stays busy 1..4 cycles
    always @(posedge clock) begin
        #1;
        case (rtl_mode)
            0:       bus.ready_to_load = 1'b1;
            1:       bus.ready_to_load = ~bus.ready_to_load;
            default: bus.ready_to_load = 1'($urandom % 2);
        endcase
        if (acc) begin rts_hold = $urandom_range(1, 4); acc = 0; end
        if (rts_hold > 0) begin bus.ready_to_send = 1'b0; rts_hold--; end
        else bus.ready_to_send = 1'b1;
        bus2.ready_to_load = 1'($urandom % 2);
        if (acc2) begin hold2 = 2; acc2 = 0; end
        if (hold2 > 0) begin bus2.ready_to_send = 1'b0; hold2--; end
        else bus2.ready_to_send = 1'b1;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.load_color) begin
                got_q.push_back({bus.pixel_index, bus.color_index, bus.color_level});
                got_cyc.push_back(cyc);
                check_eq("wr_ready_in_load", 32'(bus.wr_ready), 0);
            end
            if (!bus.busy)
                check_eq("idle_outputs_zero", 32'({bus.load_color, bus.send_it, bus.pixel_index,
                                                  bus.color_index, bus.color_level}), 0);
            if (bus.send_it) begin
                if (first_send < 0) first_send = cyc;
                if (bus.ready_to_send) begin sends_seen++; acc = 1; end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            idle2 = 0; armed2 = 0;
        end else begin
            if (bus2.load_color) begin
                loads2++;
                load2_val = {bus2.pixel_index, bus2.color_index, bus2.color_level};
            end
            if (!bus2.busy) idle2++;
            if (bus2.send_it && bus2.ready_to_send) begin
                acc2 = 1;
                if (armed2) begin check_eq("refresh_gap", idle2, 20); gaps2++; end
                armed2 = 1;
                idle2 = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input logic [2:0] p, input logic [1:0] c, input logic [7:0] l);
        bus.wr_valid = 1'b1; bus.wr_pixel = p; bus.wr_color = c; bus.wr_level = l;
        @(negedge clock);
        check_eq("wr_ready_idle", 32'(bus.wr_ready), 1);
        if (bus.wr_ready && c != 2'b11 && int'(p) < NP) begin
            m_level[int'(p) * 3 + int'(c)] = l;
            m_dirty[int'(p) * 3 + int'(c)] = 1'b1;
        end
        tick;
        bus.wr_valid = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit hold_commit);
        bit done;
        int base;
        done = 0;
        rtl_mode = mode;
        exp_q.delete(); got_q.delete(); got_cyc.delete();
        for (int e = 0; e < NE; e++)
            if (m_dirty[e]) begin
                exp_q.push_back({3'(e / 3), 2'(e % 3), m_level[e]});
                m_dirty[e] = 1'b0;
            end
        base = sends_seen;
        first_send = -1;
        commit_cyc = cyc;
        bus.commit = 1'b1; tick; bus.commit = 1'b0;
        if (hold_commit) begin
            for (int i = 0; i < 1000 && sends_seen == base; i++) @(negedge clock);
            tick;
            bus.commit = 1'b1; tick; bus.commit = 1'b0;
            m_frames++;
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (sends_seen >= base + (hold_commit ? 2 : 1) && !bus.busy) begin done = 1; break; end
        end
        check_eq("frame_done", 32'(done), 1);
        m_frames++;
        check_eq("load_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq("load_entry", 32'(got_q[i]), 32'(exp_q[i]));
        check_eq("frames_sent", 32'(bus.frames_sent), 32'(m_frames));
        tick;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_ready"}, 32'(bus.wr_ready), 1);
        check_eq({tag, "_busy"}, 32'(bus.busy), 0);
        check_eq({tag, "_frames"}, 32'(bus.frames_sent), 0);
        check_eq({tag, "_load_color"}, 32'(bus.load_color), 0);
        check_eq({tag, "_send_it"}, 32'(bus.send_it), 0);
        check_eq({tag, "_data"}, 32'({bus.pixel_index, bus.color_index, bus.color_level}), 0);
    endtask

    initial begin
        bus.wr_valid = 0; bus.wr_pixel = 0; bus.wr_color = 0; bus.wr_level = 0; bus.commit = 0;
        bus.ready_to_load = 1; bus.ready_to_send = 1;
        bus2.wr_valid = 0; bus2.wr_pixel = 0; bus2.wr_color = 0; bus2.wr_level = 0; bus2.commit = 0;
        bus2.ready_to_load = 1; bus2.ready_to_send = 1;
        for (int e = 0; e < NE; e++) begin m_level[e] = 8'd0; m_dirty[e] = 1'b0; end

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick;

        bus2.wr_valid = 1'b1; bus2.wr_pixel = 3'd0; bus2.wr_color = 2'd0; bus2.wr_level = 8'h3C;
        tick;
        bus2.wr_valid = 1'b0; bus2.commit = 1'b1;
        tick;
        bus2.commit = 1'b0;

        // single dirty byte at entry 6: load at t+1+6, SEND at t+1+15
        host_write(3'd2, 2'b00, 8'hA5);
        run_frame(0, 0);
        check_eq("load_latency", (got_cyc.size() > 0) ? got_cyc[0] : -1, commit_cyc + 7);
        check_eq("send_latency", first_send, commit_cyc + 16);

        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) host_write(3'(p), 2'(c), 8'($urandom));
        run_frame(1, 0);

        host_write(3'd1, 2'b10, 8'h5A);
        run_frame(2, 1);

        host_write(3'd3, 2'b11, 8'hFF);
        host_write(3'd6, 2'b00, 8'h11);
        host_write(3'd7, 2'b01, 8'h22);
        run_frame(0, 0);
        check_eq("reserved_loads", got_q.size(), 0);

        repeat (10) begin
            int n;
            n = $urandom_range(0, 12);
            repeat (n) host_write(3'($urandom), 2'($urandom), 8'($urandom));
            run_frame($urandom_range(0, 2), 0);
        end

        // enough empty frames to carry frames_sent through 255 -> 0
        repeat (245) run_frame(0, 0);

        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++) host_write(3'(p), 2'(c), 8'($urandom));
        rtl_mode = 0;
        commit_cyc = cyc;
        bus.commit = 1'b1; tick; bus.commit = 1'b0;
        for (int i = 0; i < 10 && cyc < commit_cyc + 3; i++) @(negedge clock);
        check_eq("load_before_reset", 32'(bus.load_color), 1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int e = 0; e < NE; e++) begin m_level[e] = 8'd0; m_dirty[e] = 1'b0; end
        m_frames = 8'd0;
        tick;
        run_frame(0, 0);
        check_eq("post_reset_loads", got_q.size(), 0);

        repeat (50) tick;
        check_eq("refresh_loads", loads2, 1);
        check_eq("refresh_load_value", 32'(load2_val), 32'({3'd0, 2'd0, 8'h3C}));
        check_eq("refresh_gap_seen", 32'(gaps2 >= 2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/neo_frame_sequencer.md
# neo_frame_sequencer

Upstream feeder for the NeoPixel strand controller. Host writes per-pixel colour bytes into a local shadow frame; on `commit` the block replays only the changed bytes into the controller over its load handshake, then issues `send_it`. An optional periodic refresh re-sends the last frame without reloading.

## Interface
Parameters:
- NUM_PIXELS, 5: pixels in strand; pixel index width is 3 bits, so at most 8.
- REFRESH_CYCLES, 0: clocks from last send to automatic re-send; 0 disables refresh.

Ports:
- clock  in  1  system clock (50 MHz, shared with controller)
- reset_n  in  1  one clock; reset is asynchronous and active-low
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted when wr_valid && wr_ready
- wr_pixel  in  3  target pixel
- wr_color  in  2  00 red, 01 blue, 10 green, 11 reserved
- wr_level  in  8  colour byte
- commit  in  1  single-cycle request to push the frame to the strand
- ready_to_load  in  1  from controller
- ready_to_send  in  1  from controller
- color_level  out  8  to controller
- color_index  out  2  to controller
- pixel_index  out  3  to controller
- load_color  out  1  to controller
- send_it  out  1  to controller
- busy  out  1  high in any state other than IDLE
- frames_sent  out  8  wrapping count of accepted sends

## Operation
- Storage: shadow[NUM_PIXELS][3] bytes plus one dirty bit per byte; reset clears every byte and every dirty bit.
- Host write: on accept, store wr_level and set the dirty bit.
- Reserved colour: wr_color = 11, or wr_pixel >= NUM_PIXELS, is accepted and discarded with no state change.
- Rewrite: a second write to a dirty byte overwrites it and the byte stays dirty.
- wr_ready = 1 in IDLE, SEND and HOLD; 0 in LOAD.
- FSM states:
  - IDLE: on commit, or on pending_commit, go to LOAD with scan = 0. Else, when REFRESH_CYCLES > 0 and refresh_cnt == REFRESH_CYCLES-1, go to SEND.
  - LOAD: scan walks the linear entries 0 .. 3*NUM_PIXELS-1, with entry = pixel*3 + color.
    - Clean entry: advance one entry per cycle.
    - Dirty entry: drive pixel_index, color_index, color_level and load_color = ready_to_load. Advance and clear the dirty bit only on the cycle ready_to_load = 1.
    - Last entry done: go to SEND.
  - SEND: send_it = ready_to_send. On the cycle ready_to_send = 1, go to HOLD and increment frames_sent.
  - HOLD: wait for ready_to_send = 0, the controller acknowledging by leaving idle, then return to IDLE and clear refresh_cnt.
- pending_commit: a commit arriving outside IDLE sets this flag; IDLE services it. A commit in the IDLE cycle itself is serviced directly.
- Writes during SEND and HOLD set dirty bits. These are sent by the next commit, not by the current frame.
- Commit with no dirty bits: LOAD still scans (3*NUM_PIXELS cycles, no load_color), then SEND.
- refresh_cnt: counts in IDLE only and saturates at REFRESH_CYCLES-1. Commit takes priority over refresh in the same cycle.
- Outputs when not active:
  - color_level, color_index and pixel_index are 0 outside LOAD.
  - load_color is 0 outside LOAD.
  - send_it is 0 outside SEND.

## Timing
- Reset values: all outputs 0 except wr_ready = 1; state IDLE; frames_sent = 0.
- Assertion of reset_n low mid-LOAD or mid-SEND:
  - load_color and send_it drop asynchronously.
  - All dirty bits clear.
  - The controller is reset by the same net.
- commit at cycle t: LOAD active at t+1. With ready_to_load held 1, SEND is entered at t+1+3*NUM_PIXELS.
- load_color and send_it are combinational from state plus the ready inputs. No extra cycle is added.
- Each accepted load occupies exactly one cycle. Back-to-back dirty entries give consecutive load_color pulses.
- frames_sent increments on the clock edge ending the send_it && ready_to_send cycle, and wraps 255 -> 0.

## Structure
- Shared package neo_pkg:
  - color_index encodings COLOR_RED = 2'b00, COLOR_BLUE = 2'b01, COLOR_GREEN = 2'b10
  - state enum {IDLE, LOAD, SEND, HOLD}
  - MAX_PIXELS = 8
- Sub-module neo_shadow_frame: byte array plus dirty bits, with one write port (host), one read port (scan) and a clear-dirty strobe.
- Reuse the existing counter for refresh_cnt.

## Test plan
- Reset, write pixel 2 red = 8'hA5, commit, ready_to_load = 1 -> exactly one load_color (pixel 2, index 00, level A5) at t+1+6, then send_it, frames_sent = 1.
- Write all 15 bytes, commit, toggle ready_to_load 1/0 every cycle -> 15 loads in scan order, none dropped or duplicated, wr_ready = 0 throughout LOAD.
- Commit asserted during HOLD -> a second LOAD pass begins from IDLE with no loads issued, then frames_sent = 2.
- REFRESH_CYCLES = 20, no commits after the first frame -> send_it re-asserts 20 cycles after each HOLD exit, no load_color.
- Write with wr_color = 11 and with wr_pixel = 6 -> accepted, shadow and dirty bits unchanged, commit produces zero loads.
- reset_n low for 1 cycle mid-LOAD -> all outputs return to reset values immediately, dirty bits cleared, next commit produces zero loads.
